bit_serializer: RTL and testbench

- Upstream feeder for the serial sequence-detector stage.
- Accepts parallel words through a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out one bit per clock on sout, which drives the detector's x input.
- sout_valid marks cycles in which sout carries a real bit.

---
 rtl/bit_serializer.sv | 148 ++++++++++++++
 tb/tb_bit_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: FIFO-buffered words shifted out one bit per clock on sout.
// Optional even-parity trailer bit enabled by defining BIT_SERIALIZER_PARITY_EN.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     cp,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int IW = $clog2(N);
    localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [N-1:0]     shreg, shregNext, frame;
    logic [IW-1:0]    bitIdx, bitIdxNext;
    logic             soutNext, soutValidNext;
    logic             push, pop, loadWord;

    assign din_ready = (level < FULL_LEVEL);
    assign push      = din_valid && din_ready;
    assign busy      = (state == SHIFT);

    // The frame is arranged so that the parity bit, when present, is always emitted last.
    always_comb begin
`ifdef BIT_SERIALIZER_PARITY_EN
        if (MSB_FIRST) begin
            frame = {mem[rdPtr], ^mem[rdPtr]};
        end else begin
            frame = {^mem[rdPtr], mem[rdPtr]};
        end
`else
        frame = mem[rdPtr];
`endif
    end

    always_comb begin
        stateNext     = state;
        shregNext     = shreg;
        bitIdxNext    = bitIdx;
        soutNext      = 1'b0;
        soutValidNext = 1'b0;
        loadWord      = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    loadWord = 1'b1;
                end
            end
            SHIFT: begin
                if (bitIdx != LAST_IDX) begin
                    bitIdxNext    = bitIdx + 1'b1;
                    soutValidNext = 1'b1;
                    if (MSB_FIRST) begin
                        soutNext  = shreg[N-1];
                        shregNext = shreg << 1;
                    end else begin
                        soutNext  = shreg[0];
                        shregNext = shreg >> 1;
                    end
                end else if (level != '0) begin
                    loadWord = 1'b1;
                end else begin
                    stateNext  = IDLE;
                    bitIdxNext = '0;
                end
            end
            default: stateNext = IDLE;
        endcase

        // Loading presents the first bit on the same edge so consecutive words have no gap.
        if (loadWord) begin
            stateNext     = SHIFT;
            bitIdxNext    = '0;
            soutValidNext = 1'b1;
            if (MSB_FIRST) begin
                soutNext  = frame[N-1];
                shregNext = frame << 1;
            end else begin
                soutNext  = frame[0];
                shregNext = frame >> 1;
            end
        end
    end

    assign pop = loadWord;

    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bitIdx     <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
        end else begin
            state      <= stateNext;
            shreg      <= shregNext;
            bitIdx     <= bitIdxNext;
            sout       <= soutNext;
            sout_valid <= soutValidNext;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wrPtr] <= din;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance share clock and reset.
// Expected frame length follows BIT_SERIALIZER_PARITY_EN.
module tb_bit_serializer;

    localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int N   = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int N   = W;
    localparam bit PAR = 1'b0;
`endif

    logic       cp = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dinM, dinL;
    logic       validM, validL;
    logic       readyM, readyL, soutM, soutL, svM, svL, busyM, busyL;
    logic [2:0] levelM, levelL;

    int compared = 0;
    int mismatched = 0;

    always #5 cp = ~cp;

    bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dutM (
        .cp(cp), .reset(reset), .din(dinM), .din_valid(validM), .din_ready(readyM),
        .sout(soutM), .sout_valid(svM), .busy(busyM), .level(levelM)
    );

    bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dutL (
        .cp(cp), .reset(reset), .din(dinL), .din_valid(validL), .din_ready(readyL),
        .sout(soutL), .sout_valid(svL), .busy(busyL), .level(levelL)
    );

    typedef struct {
        bit         lsb;
        logic [7:0] word;
        logic [7:0] expSeq;
        logic       expPar;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    task automatic applyStimulus(input bit lsb, input logic [7:0] word);
        if (lsb) begin
            dinL   = word;
            validL = 1'b1;
        end else begin
            dinM   = word;
            validM = 1'b1;
        end
        tick();
        validL = 1'b0;
        validM = 1'b0;
    endtask

    initial begin
        logic       expBit;
        logic       sSel, vSel, bSel;
        logic [2:0] lSel;
        int         validCount;
        logic [17:0] expB2B;
        logic       q [$];
        int         nextWord, acceptEdge6;
        bit         acc;
        logic [7:0] rebuilt;
        logic [7:0] wordVal;

        validM = 1'b0; validL = 1'b0; dinM = '0; dinL = '0;

        // expSeq lists bits in emission order, first emitted at bit 7
        vecs[0] = '{1'b0, 8'hD0, 8'b11010000, 1'b1};
        vecs[1] = '{1'b0, 8'h07, 8'b00000111, 1'b1};
        vecs[2] = '{1'b0, 8'hA5, 8'b10100101, 1'b0};
        vecs[3] = '{1'b1, 8'h0B, 8'b11010000, 1'b1};
        vecs[4] = '{1'b1, 8'h80, 8'b00000001, 1'b1};
        vecs[5] = '{1'b1, 8'h3C, 8'b00111100, 1'b0};
        vecs[6] = '{1'b0, 8'hFF, 8'b11111111, 1'b0};

        #1 reset = 1'b1;
        #2;
        checkOutput("reset sout", soutM, 0);
        checkOutput("reset sout_valid", svM, 0);
        checkOutput("reset busy", busyM, 0);
        checkOutput("reset level", levelM, 0);
        checkOutput("reset din_ready", readyM, 1);
        checkOutput("reset lsb din_ready", readyL, 1);
        repeat (2) @(posedge cp);
        @(negedge cp) reset = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].lsb, vecs[v].word);
            validCount = 0;
            for (int b = 0; b < N; b++) begin
                tick();
                expBit = (b < W) ? vecs[v].expSeq[W-1-b] : vecs[v].expPar;
                sSel = vecs[v].lsb ? soutL : soutM;
                vSel = vecs[v].lsb ? svL : svM;
                bSel = vecs[v].lsb ? busyL : busyM;
                checkOutput($sformatf("vec%0d bit%0d sout", v, b), sSel, expBit);
                checkOutput($sformatf("vec%0d bit%0d valid", v, b), vSel, 1);
                checkOutput($sformatf("vec%0d bit%0d busy", v, b), bSel, 1);
                if (vSel) validCount++;
            end
            tick();
            vSel = vecs[v].lsb ? svL : svM;
            sSel = vecs[v].lsb ? soutL : soutM;
            bSel = vecs[v].lsb ? busyL : busyM;
            lSel = vecs[v].lsb ? levelL : levelM;
            checkOutput($sformatf("vec%0d end valid", v), vSel, 0);
            checkOutput($sformatf("vec%0d end sout", v), sSel, 0);
            checkOutput($sformatf("vec%0d end busy", v), bSel, 0);
            checkOutput($sformatf("vec%0d end level", v), lSel, 0);
            checkOutput($sformatf("vec%0d valid count", v), validCount, N);
        end

        // Back-to-back words must stream without an idle cycle.
`ifdef BIT_SERIALIZER_PARITY_EN
        expB2B = {8'b10101010, 1'b0, 8'b01010101, 1'b0};
`else
        expB2B = {2'b00, 16'b1010101001010101};
`endif
        dinM = 8'hAA; validM = 1'b1;
        tick();
        dinM = 8'h55;
        tick();
        validM = 1'b0;
        for (int b = 0; b < 2 * N; b++) begin
            if (b > 0) tick();
            checkOutput($sformatf("b2b bit%0d sout", b), soutM, expB2B[2*N-1-b]);
            checkOutput($sformatf("b2b bit%0d valid", b), svM, 1);
        end
        tick();
        checkOutput("b2b end valid", svM, 0);
        checkOutput("b2b end level", levelM, 0);

        // Backpressure: din_valid held high with words 1..6.
        nextWord = 1;
        acceptEdge6 = 0;
        q.delete();
        for (int e = 1; e <= 200; e++) begin
            validM = (nextWord <= 6);
            dinM   = nextWord[7:0];
            acc    = validM && readyM;
            tick();
            if (acc) begin
                if (nextWord == 6) acceptEdge6 = e;
                nextWord++;
            end
            if (svM) q.push_back(soutM);
            if (e == 5) checkOutput("bp level at edge5", levelM, 4);
            if (e >= 5 && e < 2 + N) checkOutput($sformatf("bp ready edge%0d", e), readyM, 0);
            if (e == 2 + N) checkOutput("bp ready after pop2", readyM, 1);
            if (q.size() == 6 * N) break;
        end
        validM = 1'b0;
        checkOutput("bp bit count", q.size(), 6 * N);
        checkOutput("bp word6 accept edge", acceptEdge6, 3 + N);
        for (int w = 0; w < 6; w++) begin
            if (q.size() >= (w + 1) * N) begin
                rebuilt = '0;
                for (int b = 0; b < W; b++) rebuilt = {rebuilt[6:0], q[w*N+b]};
                checkOutput($sformatf("bp word%0d", w + 1), rebuilt, w + 1);
                if (PAR) begin
                    wordVal = 8'(w + 1);
                    checkOutput($sformatf("bp word%0d parity", w + 1), q[w*N+W], ^wordVal);
                end
            end
        end
        tick();
        checkOutput("bp end valid", svM, 0);
        checkOutput("bp end level", levelM, 0);

        // Asynchronous reset in the middle of a word with two words queued.
        applyStimulus(1'b0, 8'hFF);
        dinM = 8'h11; validM = 1'b1;
        tick();
        dinM = 8'h22;
        tick();
        validM = 1'b0;
        tick();
        tick();
        checkOutput("ar pre valid", svM, 1);
        checkOutput("ar pre level", levelM, 2);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar sout_valid", svM, 0);
        checkOutput("ar busy", busyM, 0);
        checkOutput("ar level", levelM, 0);
        checkOutput("ar sout", soutM, 0);
        checkOutput("ar din_ready", readyM, 1);
        #2 reset = 1'b0;
        validCount = 0;
        for (int c = 0; c < 3 * N; c++) begin
            tick();
            if (svM) validCount++;
        end
        checkOutput("ar residual bits", validCount, 0);
        checkOutput("ar residual level", levelM, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
